led_seq_ctrl: RTL and testbench

Avalon-MM sequencer that drives the 8-bit LED PIO slave so the Nios II core does not have to bit-bang LED patterns. It exposes a 4-word CSR slave to the CPU (enable, mode, period, seed) and a zero-wait-state write-only master port wired straight to the PIO slave's address/chipselect/write_n/writedata inputs. Once started it autonomously steps a pattern (static, walk, ping-pong, binary count) and writes it to the PIO at a programmable tick period.

---
 rtl/led_seq_pkg.sv | 31 +++
 rtl/led_seq_tick.sv | 30 +++
 rtl/led_seq_ctrl.sv | 179 +++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and constants for the LED sequencer
// Macro LED_SEQ_PINGPONG_EN (consumed by led_seq_ctrl) enables true ping-pong mode.
package led_seq_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC   = 2'd0,
    MODE_WALK     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_COUNT    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_PERIOD = 2'd1;
  localparam logic [1:0] CSR_SEED   = 2'd2;
  localparam logic [1:0] CSR_STATUS = 2'd3;

  localparam logic        RST_ENABLE = 1'b0;
  localparam mode_e       RST_MODE   = MODE_STATIC;
  localparam int unsigned RST_PERIOD = 1;
  localparam int unsigned RST_SEED   = 0;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/led_seq_tick.sv
// rtl/led_seq_tick.sv - loadable down-counter producing a one-cycle tick at zero
// A period of 0 behaves as 1, so the counter then ticks every cycle.
module led_seq_tick #(
  parameter int PERIOD_W = 24
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                restart,
  input  logic                run,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] count;
  logic [PERIOD_W-1:0] reload;

  assign reload = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign tick   = run && (count == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (restart) begin
      count <= reload;
    end else if (run) begin
      count <= tick ? reload : count - PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - CSR slave, sequencing FSM and PIO write master for the LED pattern
// Define LED_SEQ_PINGPONG_EN for true ping-pong in mode 2; otherwise mode 2 walks.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int PERIOD_W = 24,
  parameter int LED_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_chipselect,
  input  logic        avs_write_n,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata
);

  logic                ctrl_en;
  mode_e               ctrl_mode;
  logic [PERIOD_W-1:0] period;
  logic [LED_W-1:0]    seed;
  logic [LED_W-1:0]    pattern;
  logic [LED_W-1:0]    nxt_pat;
  logic                dir;
  state_e              state_q, state_d;
  logic                csr_wr, wr_ctrl, wr_period, wr_seed;
  logic                en_next;
  logic                tick;
  logic                do_write;
  logic                wr_strobe;
  logic                unused_wdata;

  assign csr_wr       = avs_chipselect && !avs_write_n;
  assign wr_ctrl      = csr_wr && (avs_address == CSR_CTRL);
  assign wr_period    = csr_wr && (avs_address == CSR_PERIOD);
  assign wr_seed      = csr_wr && (avs_address == CSR_SEED);
  assign unused_wdata = ^avs_writedata;

  // FSM reacts to a CTRL write in its own cycle; ticks keep using the registered values
  assign en_next = wr_ctrl ? avs_writedata[0] : ctrl_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_en   <= RST_ENABLE;
      ctrl_mode <= RST_MODE;
      period    <= PERIOD_W'(RST_PERIOD);
      seed      <= LED_W'(RST_SEED);
    end else begin
      if (wr_ctrl) begin
        ctrl_en   <= avs_writedata[0];
        ctrl_mode <= mode_e'(avs_writedata[2:1]);
      end
      if (wr_period) period <= avs_writedata[PERIOD_W-1:0];
      if (wr_seed)   seed   <= avs_writedata[LED_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (en_next) state_d = ST_START;
      end
      ST_START: begin
        if (!en_next)     state_d = ST_IDLE;
        else if (wr_seed) state_d = ST_START;
        else              state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!en_next)     state_d = ST_IDLE;
        else if (wr_seed) state_d = ST_START;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  led_seq_tick #(
    .PERIOD_W (PERIOD_W)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (state_q == ST_START),
    .run     (state_q == ST_RUN),
    .period  (period),
    .tick    (tick)
  );

`ifdef LED_SEQ_PINGPONG_EN
  logic nxt_dir;
`endif

  always_comb begin
    nxt_pat = pattern;
`ifdef LED_SEQ_PINGPONG_EN
    nxt_dir = dir;
`endif
    case (ctrl_mode)
      MODE_WALK: nxt_pat = {pattern[LED_W-2:0], pattern[LED_W-1]};
      MODE_PINGPONG: begin
`ifdef LED_SEQ_PINGPONG_EN
        if (dir == DIR_LEFT && pattern[LED_W-1]) begin
          nxt_dir = DIR_RIGHT;
          nxt_pat = pattern >> 1;
        end else if (dir == DIR_RIGHT && pattern[0]) begin
          nxt_dir = DIR_LEFT;
          nxt_pat = pattern << 1;
        end else if (dir == DIR_RIGHT) begin
          nxt_pat = pattern >> 1;
        end else begin
          nxt_pat = pattern << 1;
        end
`else
        nxt_pat = {pattern[LED_W-2:0], pattern[LED_W-1]};
`endif
      end
      MODE_COUNT: nxt_pat = pattern + LED_W'(1);
      default:    nxt_pat = pattern;
    endcase
  end

`ifdef LED_SEQ_PINGPONG_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 dir <= DIR_LEFT;
    else if (state_q == ST_START) dir <= DIR_LEFT;
    else if (tick)                dir <= nxt_dir;
  end
`else
  assign dir = DIR_LEFT;
`endif

  // Static mode still ticks but never re-writes the unchanged pattern
  assign do_write  = tick && (ctrl_mode != MODE_STATIC);
  assign wr_strobe = (state_q == ST_START) || do_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern        <= '0;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_writedata  <= '0;
    end else begin
      pio_chipselect <= wr_strobe;
      pio_write_n    <= ~wr_strobe;
      if (state_q == ST_START) begin
        pattern       <= seed;
        pio_writedata <= {{(32-LED_W){1'b0}}, seed};
      end else if (do_write) begin
        pattern       <= nxt_pat;
        pio_writedata <= {{(32-LED_W){1'b0}}, nxt_pat};
      end
    end
  end

  assign pio_address = 2'b00;

  always_comb begin
    avs_readdata = '0;
    case (avs_address)
      CSR_CTRL:   avs_readdata[2:0]          = {ctrl_mode, ctrl_en};
      CSR_PERIOD: avs_readdata[PERIOD_W-1:0] = period;
      CSR_SEED:   avs_readdata[LED_W-1:0]    = seed;
      default: begin
        avs_readdata[0]         = (state_q != ST_IDLE);
        avs_readdata[1]         = dir;
        avs_readdata[8 +: LED_W] = pattern;
      end
    endcase
  end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed self-checking bench for led_seq_ctrl
// Expectations follow LED_SEQ_PINGPONG_EN when it is defined for the build.
module tb_led_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  avs_address;
  logic        avs_chipselect;
  logic        avs_write_n;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  data;
  } wr_t;

  wr_t         wq[$];
  wr_t         tmp;
  int unsigned cyc = 0;
  int unsigned last_wr_cyc;
  int unsigned s;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  exp_q[];

  led_seq_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_write_n    (avs_write_n),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .pio_address    (pio_address),
    .pio_chipselect (pio_chipselect),
    .pio_write_n    (pio_write_n),
    .pio_writedata  (pio_writedata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Record every PIO write with the cycle it appeared in
  always @(posedge clk) begin
    #1;
    if (pio_chipselect === 1'b1) begin
      wq.push_back('{cyc: cyc, data: pio_writedata[7:0]});
      check("pio_ctl", {8'h00, pio_write_n, pio_address, pio_writedata[31:8]}, 32'h0);
    end
  end

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    avs_address    = a;
    avs_chipselect = 1'b1;
    avs_write_n    = 1'b0;
    avs_writedata  = d;
    last_wr_cyc    = cyc;
    @(negedge clk);
    avs_chipselect = 1'b0;
    avs_write_n    = 1'b1;
  endtask

  task automatic csr_read(input logic [1:0] a, input logic [31:0] exp, input string tag);
    @(negedge clk);
    avs_address = a;
    #1;
    check(tag, avs_readdata, exp);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k = 0;
    while (wq.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (wq.size() < n) check("timeout", 32'(wq.size()), 32'(n));
  endtask

  task automatic check_seq(input string tag, input logic [7:0] e[], input int unsigned base,
                           input int unsigned spacing);
    for (int i = 0; i < e.size(); i++) begin
      if (i < wq.size()) begin
        check($sformatf("%s_d%0d", tag, i), 32'(wq[i].data), 32'(e[i]));
        check($sformatf("%s_c%0d", tag, i), wq[i].cyc, base + spacing * i);
      end else begin
        check($sformatf("%s_missing%0d", tag, i), 32'(wq.size()), 32'(i + 1));
      end
    end
  endtask

  task automatic stop_and_clear(input logic [31:0] ctrl_off);
    csr_write(2'd0, ctrl_off);
    repeat (4) @(negedge clk);
    wq.delete();
  endtask

  initial begin
    reset_n        = 1'b0;
    avs_address    = 2'd0;
    avs_chipselect = 1'b0;
    avs_write_n    = 1'b1;
    avs_writedata  = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_cs", {31'h0, pio_chipselect}, 32'h0);
    check("rst_wn", {31'h0, pio_write_n}, 32'h1);
    check("rst_wd", pio_writedata, 32'h0);
    check("rst_addr", {30'h0, pio_address}, 32'h0);
    reset_n = 1'b1;

    csr_read(2'd0, 32'h0, "rst_ctrl");
    csr_read(2'd1, 32'h1, "rst_period");
    csr_read(2'd2, 32'h0, "rst_seed");
    csr_read(2'd3, 32'h0, "rst_status");
    repeat (100) @(negedge clk);
    check("idle_nowr", 32'(wq.size()), 32'h0);

    // Walk, period 4
    csr_write(2'd2, 32'h01);
    csr_write(2'd1, 32'd4);
    wq.delete();
    csr_write(2'd0, 32'h3);
    s = last_wr_cyc;
    wait_writes(10, 60);
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
    check_seq("walk", exp_q, s + 2, 4);
    stop_and_clear(32'h2);

    // Mode 2, period 1, stopped after 16 writes
    csr_write(2'd1, 32'd1);
    wq.delete();
    csr_write(2'd0, 32'h5);
    s = last_wr_cyc;
    repeat (14) @(negedge clk);
    csr_write(2'd0, 32'h4);
    repeat (4) @(negedge clk);
    check("pp_n16", 32'(wq.size()), 32'd16);
`ifdef LED_SEQ_PINGPONG_EN
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    check_seq("pp", exp_q, s + 2, 1);
    csr_read(2'd3, 32'h0000_0200, "pp_status16");
`else
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
              8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
    check_seq("pp", exp_q, s + 2, 1);
    csr_read(2'd3, 32'h0000_8000, "pp_status16");
`endif

    // Re-enable restarts from SEED; stop right after the top bounce
    wq.delete();
    csr_write(2'd0, 32'h5);
    s = last_wr_cyc;
    repeat (7) @(negedge clk);
    csr_write(2'd0, 32'h4);
    repeat (4) @(negedge clk);
    check("pp_n9", 32'(wq.size()), 32'd9);
`ifdef LED_SEQ_PINGPONG_EN
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
    check_seq("pp9", exp_q, s + 2, 1);
    csr_read(2'd3, 32'h0000_4002, "pp_status9");
`else
    exp_q = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    check_seq("pp9", exp_q, s + 2, 1);
    csr_read(2'd3, 32'h0000_0100, "pp_status9");
`endif
    stop_and_clear(32'h0);

    // Count mode wraps FF -> 00
    csr_write(2'd2, 32'hFE);
    csr_write(2'd1, 32'd2);
    wq.delete();
    csr_write(2'd0, 32'h7);
    s = last_wr_cyc;
    wait_writes(4, 40);
    exp_q = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    check_seq("cnt", exp_q, s + 2, 2);
    stop_and_clear(32'h6);

    // Static mode writes SEED once only
    csr_write(2'd2, 32'h3C);
    wq.delete();
    csr_write(2'd0, 32'h1);
    repeat (20) @(negedge clk);
    check("static_n", 32'(wq.size()), 32'd1);
    exp_q = '{8'h3C};
    check_seq("static", exp_q, last_wr_cyc + 2, 1);
    stop_and_clear(32'h0);

    // SEED 0 with PERIOD 0: zeros written every cycle
    csr_write(2'd2, 32'h00);
    csr_write(2'd1, 32'd0);
    csr_read(2'd1, 32'h0, "period0_rd");
    wq.delete();
    csr_write(2'd0, 32'h3);
    s = last_wr_cyc;
    wait_writes(3, 20);
    exp_q = '{8'h00, 8'h00, 8'h00};
    check_seq("zero", exp_q, s + 2, 1);
    stop_and_clear(32'h2);

    // SEED write mid-walk restarts the sequence and the period
    csr_write(2'd2, 32'h01);
    csr_write(2'd1, 32'd4);
    wq.delete();
    csr_write(2'd0, 32'h3);
    wait_writes(3, 40);
    csr_write(2'd2, 32'h55);
    s = last_wr_cyc;
    repeat (6) @(negedge clk);
    while (wq.size() > 0 && wq[0].cyc <= s + 1) tmp = wq.pop_front();
    check("reseed_n", 32'(wq.size()), 32'd2);
    exp_q = '{8'h55, 8'hAA};
    check_seq("reseed", exp_q, s + 2, 4);

    // Reset mid-run with continuous writes
    csr_write(2'd1, 32'd1);
    wq.delete();
    wait_writes(2, 20);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cs", {31'h0, pio_chipselect}, 32'h0);
    check("mid_rst_wd", pio_writedata, 32'h0);
    check("mid_rst_wn", {31'h0, pio_write_n}, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    wq.delete();
    csr_read(2'd3, 32'h0, "post_rst_status");
    csr_read(2'd0, 32'h0, "post_rst_ctrl");
    repeat (10) @(negedge clk);
    check("post_rst_nowr", 32'(wq.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
